// File: rtl/nios2_ocimem_access_ctrl_if.sv
// Memory master port of the debug-memory access controller: one word per access,
// slave stalls with waitrequest, read data returns one cycle after acceptance.
interface nios2_ocimem_access_ctrl_if #(
  parameter int ADDR_W = 8
) ();
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_waitrequest;

  modport master (
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_readdata, mem_waitrequest
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_readdata, mem_waitrequest
  );
endinterface

// File: rtl/nios2_ocimem_access_ctrl.sv
// System-clock side of the Nios II JTAG debug memory path: turns decoded take pulses
// into single-word memory accesses with an auto-incrementing address register.
module nios2_ocimem_access_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  nios2_ocimem_access_ctrl_if.master mem
);

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_DATA} state_e;

  // Count value on the last stalled cycle a request is still allowed to be held.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       dreg_q, dreg_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic              any_cmd;
  logic              unused_jdo;

  assign any_cmd    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_jdo = ^{jdo[37], jdo[35], jdo[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dreg_q  <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dreg_q  <= dreg_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dreg_d  = dreg_q;
    ready_d = ready_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (take_action_ocimem_a) begin
          addr_d = jdo[ADDR_W+2:3];
          if (jdo[36]) err_d = 1'b0;
        end else if (take_action_ocimem_b) begin
          dreg_d  = jdo[34:3];
          ready_d = 1'b0;
          wcnt_d  = '0;
          state_d = WR_REQ;
        end else if (take_no_action_ocimem_a) begin
          ready_d = 1'b0;
          wcnt_d  = '0;
          state_d = RD_REQ;
        end
      end
      WR_REQ, RD_REQ: begin
        if (!mem.mem_waitrequest) begin
          if (state_q == WR_REQ) begin
            addr_d  = addr_q + 1'b1;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RD_DATA;
          end
        end else if (wcnt_q == WAIT_LAST) begin
          // Abandon the access; address and data register keep their values.
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      RD_DATA: begin
        dreg_d  = mem.mem_readdata;
        addr_d  = addr_q + 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Host overrun: pulses while busy are dropped but flagged.
    if (state_q != IDLE && any_cmd) err_d = 1'b1;
  end

  assign mem.mem_address   = addr_q;
  assign mem.mem_read      = (state_q == RD_REQ);
  assign mem.mem_write     = (state_q == WR_REQ);
  assign mem.mem_writedata = dreg_q;
  assign MonDReg           = dreg_q;
  assign monitor_ready     = ready_q;
  assign monitor_error     = err_q;

endmodule

// File: tb/tb_nios2_ocimem_access_ctrl.sv
// Bench for nios2_ocimem_access_ctrl: two instances (TIMEOUT 255 and 4) share the command
// stream, each with its own memory slave; a transaction-level model predicts every cycle.
module tb_nios2_ocimem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        ta_a, ta_b, tn_a;
  logic        wr0, wr1;
  logic [31:0] dreg0, dreg1;
  logic        rdy0, rdy1, err0, err1;
  logic [31:0] rdata0, rdata1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nios2_ocimem_access_ctrl_if #(.ADDR_W(8)) m0 ();
  nios2_ocimem_access_ctrl_if #(.ADDR_W(8)) m1 ();

  nios2_ocimem_access_ctrl #(.ADDR_W(8), .TIMEOUT(255)) u0 (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
    .take_no_action_ocimem_a(tn_a),
    .MonDReg(dreg0), .monitor_ready(rdy0), .monitor_error(err0), .mem(m0)
  );

  nios2_ocimem_access_ctrl #(.ADDR_W(8), .TIMEOUT(4)) u1 (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
    .take_no_action_ocimem_a(tn_a),
    .MonDReg(dreg1), .monitor_ready(rdy1), .monitor_error(err1), .mem(m1)
  );

  function automatic logic [31:0] preset(input logic [7:0] a);
    return {16'hA500, 8'h5A, a};
  endfunction

  // Memory slaves: unwritten words read back as preset(address).
  logic [31:0]  s_mem0 [256];
  logic [31:0]  s_mem1 [256];
  logic [255:0] s_vld0, s_vld1;

  assign m0.mem_waitrequest = wr0;
  assign m1.mem_waitrequest = wr1;
  assign m0.mem_readdata    = rdata0;
  assign m1.mem_readdata    = rdata1;

  always @(posedge clk) begin
    if (reset) begin
      s_vld0 <= '0;
      s_vld1 <= '0;
    end else begin
      if (m0.mem_write && !wr0) begin
        s_mem0[m0.mem_address] <= m0.mem_writedata;
        s_vld0[m0.mem_address] <= 1'b1;
      end
      if (m1.mem_write && !wr1) begin
        s_mem1[m1.mem_address] <= m1.mem_writedata;
        s_vld1[m1.mem_address] <= 1'b1;
      end
      if (m0.mem_read && !wr0)
        rdata0 <= s_vld0[m0.mem_address] ? s_mem0[m0.mem_address] : preset(m0.mem_address);
      if (m1.mem_read && !wr1)
        rdata1 <= s_vld1[m1.mem_address] ? s_mem1[m1.mem_address] : preset(m1.mem_address);
    end
  end

  // Transaction-level model: op 0 none, 1 write pending, 2 read pending.
  logic [7:0]  m_addr [2];
  logic [31:0] m_dreg [2];
  bit          m_rdy  [2];
  bit          m_err  [2];
  int          m_op   [2];
  bit          m_got  [2];
  int          m_stall[2];
  logic [31:0] m_mem  [2][256];
  bit          m_mv   [2][256];
  bit          m_valid = 1'b0;

  task automatic model_step(input int k);
    bit stalled;
    int limit;
    stalled = (k == 0) ? wr0 : wr1;
    limit   = (k == 0) ? 255 : 4;
    if (reset) begin
      m_addr[k] = 8'h00; m_dreg[k] = 32'h0; m_rdy[k] = 1'b1; m_err[k] = 1'b0;
      m_op[k] = 0; m_got[k] = 1'b0;
      for (int i = 0; i < 256; i++) m_mv[k][i] = 1'b0;
      return;
    end
    if (m_op[k] == 0) begin
      if (ta_a) begin
        m_addr[k] = jdo[10:3];
        if (jdo[36]) m_err[k] = 1'b0;
      end else if (ta_b) begin
        m_dreg[k] = jdo[34:3]; m_rdy[k] = 1'b0; m_op[k] = 1; m_stall[k] = 0;
      end else if (tn_a) begin
        m_rdy[k] = 1'b0; m_op[k] = 2; m_got[k] = 1'b0; m_stall[k] = 0;
      end
      return;
    end
    if (ta_a || ta_b || tn_a) m_err[k] = 1'b1;
    if (m_op[k] == 2 && m_got[k]) begin
      m_dreg[k] = m_mv[k][m_addr[k]] ? m_mem[k][m_addr[k]] : preset(m_addr[k]);
      m_addr[k] = m_addr[k] + 8'd1; m_rdy[k] = 1'b1; m_op[k] = 0;
    end else if (!stalled) begin
      if (m_op[k] == 1) begin
        m_mem[k][m_addr[k]] = m_dreg[k]; m_mv[k][m_addr[k]] = 1'b1;
        m_addr[k] = m_addr[k] + 8'd1; m_rdy[k] = 1'b1; m_op[k] = 0;
      end else begin
        m_got[k] = 1'b1;
      end
    end else begin
      m_stall[k]++;
      if (m_stall[k] == limit) begin
        m_err[k] = 1'b1; m_rdy[k] = 1'b1; m_op[k] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    if (reset) m_valid = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int k, input logic [31:0] dreg, input logic rdy, input logic err,
                            input logic rd, input logic wrr, input logic [7:0] ad,
                            input logic [31:0] wd);
    chk($sformatf("u%0d.MonDReg", k), dreg, m_dreg[k]);
    chk($sformatf("u%0d.ready", k), {31'b0, rdy}, {31'b0, m_rdy[k]});
    chk($sformatf("u%0d.error", k), {31'b0, err}, {31'b0, m_err[k]});
    chk($sformatf("u%0d.mem_read", k), {31'b0, rd}, {31'b0, (m_op[k] == 2 && !m_got[k])});
    chk($sformatf("u%0d.mem_write", k), {31'b0, wrr}, {31'b0, (m_op[k] == 1)});
    chk($sformatf("u%0d.mem_address", k), {24'b0, ad}, {24'b0, m_addr[k]});
    chk($sformatf("u%0d.mem_writedata", k), wd, m_dreg[k]);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check_inst(0, dreg0, rdy0, err0, m0.mem_read, m0.mem_write, m0.mem_address, m0.mem_writedata);
      check_inst(1, dreg1, rdy1, err1, m1.mem_read, m1.mem_write, m1.mem_address, m1.mem_writedata);
    end
  end

  function automatic logic [37:0] j_load(input logic [7:0] ad, input bit clr);
    logic [37:0] j;
    j = '0; j[10:3] = ad; j[36] = clr;
    return j;
  endfunction

  function automatic logic [37:0] j_data(input logic [31:0] d);
    logic [37:0] j;
    j = '0; j[34:3] = d;
    return j;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse sampled at the next rising edge; returns just after that edge.
  task automatic cmd(input bit pa, input bit pb, input bit pn, input logic [37:0] j);
    @(negedge clk);
    ta_a = pa; ta_b = pb; tn_a = pn; jdo = j;
    @(negedge clk);
    ta_a = 1'b0; ta_b = 1'b0; tn_a = 1'b0; jdo = '0;
  endtask

  task automatic rand_in();
    ta_a = 1'($urandom_range(0, 1));
    ta_b = 1'($urandom_range(0, 1));
    tn_a = 1'($urandom_range(0, 1));
    jdo  = 38'({$urandom(), $urandom()});
    wr0  = 1'($urandom_range(0, 1));
    wr1  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    reset = 1'b1;
    rand_in();
    step(1);
    rand_in();
    step(1);
    chk("reset.MonDReg", dreg0, 32'h0);
    chk("reset.ready", {31'b0, rdy0}, 32'd1);
    chk("reset.error", {31'b0, err0}, 32'd0);
    chk("reset.no_req", {30'b0, m0.mem_read, m0.mem_write}, 32'd0);
    reset = 1'b0; ta_a = 1'b0; ta_b = 1'b0; tn_a = 1'b0; jdo = '0; wr0 = 1'b0; wr1 = 1'b0;

    // Load, zero-wait write, read of next word, read back.
    cmd(1, 0, 0, j_load(8'h10, 0));
    chk("load.addr", {24'b0, m0.mem_address}, 32'h10);
    cmd(0, 1, 0, j_data(32'hDEADBEEF));
    chk("wr.n1.write", {31'b0, m0.mem_write}, 32'd1);
    chk("wr.n1.addr", {24'b0, m0.mem_address}, 32'h10);
    chk("wr.n1.data", m0.mem_writedata, 32'hDEADBEEF);
    chk("wr.n1.ready", {31'b0, rdy0}, 32'd0);
    step(1);
    chk("wr.n2.ready", {31'b0, rdy0}, 32'd1);
    chk("wr.n2.addr", {24'b0, m0.mem_address}, 32'h11);
    cmd(0, 0, 1, '0);
    chk("rd.n1.read", {31'b0, m0.mem_read}, 32'd1);
    chk("rd.n1.addr", {24'b0, m0.mem_address}, 32'h11);
    step(2);
    chk("rd.n3.data", dreg0, 32'hA5005A11);
    cmd(1, 0, 0, j_load(8'h10, 0));
    cmd(0, 0, 1, '0);
    step(1);
    chk("rdback.n2.ready", {31'b0, rdy0}, 32'd0);
    step(1);
    chk("rdback.n3.data", dreg0, 32'hDEADBEEF);
    chk("rdback.n3.ready", {31'b0, rdy0}, 32'd1);

    // Address wrap.
    cmd(1, 0, 0, j_load(8'hFF, 0));
    cmd(0, 0, 1, '0);
    chk("wrap.addr0", {24'b0, m0.mem_address}, 32'hFF);
    step(2);
    cmd(0, 0, 1, '0);
    chk("wrap.addr1", {24'b0, m0.mem_address}, 32'h00);
    step(2);

    // Five-cycle stall on a read: u0 completes late, u1 (TIMEOUT 4) aborts.
    cmd(1, 0, 0, j_load(8'h20, 0));
    wr0 = 1'b1; wr1 = 1'b1;
    cmd(0, 0, 1, '0);
    step(5);
    wr0 = 1'b0; wr1 = 1'b0;
    step(1);
    chk("stall.ready_low", {31'b0, rdy0}, 32'd0);
    step(1);
    chk("stall.ready", {31'b0, rdy0}, 32'd1);
    chk("stall.data", dreg0, 32'hA5005A20);
    chk("stall.noerr", {31'b0, err0}, 32'd0);
    chk("stall.u1.err", {31'b0, err1}, 32'd1);
    chk("stall.u1.addr", {24'b0, m1.mem_address}, 32'h20);

    // Permanent stall on u1 write: held exactly 4 cycles then dropped.
    cmd(1, 0, 0, j_load(8'h30, 1));
    chk("clr.u1.err", {31'b0, err1}, 32'd0);
    wr1 = 1'b1;
    cmd(0, 1, 0, j_data(32'h0BADF00D));
    step(3);
    chk("to.held", {31'b0, m1.mem_write}, 32'd1);
    step(1);
    chk("to.dropped", {31'b0, m1.mem_write}, 32'd0);
    chk("to.err", {31'b0, err1}, 32'd1);
    chk("to.ready", {31'b0, rdy1}, 32'd1);
    chk("to.addr", {24'b0, m1.mem_address}, 32'h30);
    chk("to.data", dreg1, 32'h0BADF00D);
    wr1 = 1'b0;

    // Overrun while busy; an ignored clearing load must not clear the error.
    cmd(1, 0, 0, j_load(8'h40, 1));
    wr0 = 1'b1; wr1 = 1'b1;
    cmd(0, 0, 1, '0);
    cmd(0, 0, 1, '0);
    chk("ovr.err", {31'b0, err0}, 32'd1);
    cmd(1, 0, 0, j_load(8'h99, 1));
    wr0 = 1'b0; wr1 = 1'b0;
    step(3);
    chk("ovr.err_kept", {31'b0, err0}, 32'd1);
    chk("ovr.addr", {24'b0, m0.mem_address}, 32'h41);
    cmd(1, 0, 0, j_load(8'h50, 1));
    chk("ovr.cleared", {31'b0, err0}, 32'd0);

    // Simultaneous pulses: priority a > b > no_action.
    cmd(1, 1, 0, j_load(8'h60, 0));
    chk("ab.addr", {24'b0, m0.mem_address}, 32'h60);
    chk("ab.nowrite", {31'b0, m0.mem_write}, 32'd0);
    cmd(0, 1, 1, j_data(32'h12345678));
    chk("bn.write", {31'b0, m0.mem_write}, 32'd1);
    step(2);

    // Reset in the middle of a stalled read.
    wr0 = 1'b1; wr1 = 1'b1;
    cmd(0, 0, 1, '0);
    reset = 1'b1;
    step(1);
    reset = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    chk("rst.noread", {31'b0, m0.mem_read}, 32'd0);
    chk("rst.ready", {31'b0, rdy0}, 32'd1);
    chk("rst.addr", {24'b0, m0.mem_address}, 32'h0);

    // Mixed write/read-back sequence with short stalls.
    for (int i = 0; i < 6; i++) begin
      cmd(1, 0, 0, j_load(8'(8'h80 + i * 7), 0));
      wr0 = (i % 2 == 1); wr1 = (i % 2 == 1);
      cmd(0, 1, 0, j_data($urandom()));
      step(i % 3);
      wr0 = 1'b0; wr1 = 1'b0;
      step(3);
      cmd(1, 0, 0, j_load(8'(8'h80 + i * 7), 0));
      cmd(0, 0, 1, '0);
      step(3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nios2_ocimem_access_ctrl.md
# nios2_ocimem_access_ctrl

Debug-memory access controller on the system-clock side of the Nios II JTAG debug module. It consumes the one-cycle `take_action_ocimem_*` pulses and the `jdo` payload from the sysclk command decoder. It executes single-word reads and writes on a simple memory master port and returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug-module wrapper for JTAG capture. A built-in address register auto-increments so the host can stream consecutive words.

## Interface
Parameters:
- `ADDR_W`, 8, word-address width of the debug memory port; address field is `jdo[ADDR_W+2:3]`.
- `TIMEOUT`, 255, maximum cycles a request may be held off by `mem_waitrequest` before abort; legal range 1..65535.

Ports:
- `clk`  in  1  system clock; one clock domain; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `jdo`  in  38  command payload from sysclk decoder, valid in the cycle of a take pulse.
- `take_action_ocimem_a`  in  1  pulse: load address (and optional error clear).
- `take_action_ocimem_b`  in  1  pulse: write `jdo[34:3]` at current address.
- `take_no_action_ocimem_a`  in  1  pulse: read word at current address.
- `MonDReg`  out  32  monitor data register (last read data or last write data).
- `monitor_ready`  out  1  1 = idle, result valid; 0 = access in flight.
- `monitor_error`  out  1  sticky error flag.
- `mem_address`  out  ADDR_W  word address (equals internal address register).
- `mem_read`  out  1  read request, held until accepted.
- `mem_write`  out  1  write request, held until accepted.
- `mem_writedata`  out  32  write data (equals `MonDReg` during write).
- `mem_readdata`  in  32  read data, valid exactly one cycle after read acceptance.
- `mem_waitrequest`  in  1  slave stall; request accepted in a cycle where it is 0.

## Operation
- FSM states: IDLE, WR_REQ, RD_REQ, RD_DATA.
- IDLE, on command pulses, priority a > b > no_action; lower-priority simultaneous pulses are dropped silently:
  - `take_action_ocimem_a`: address <= `jdo[ADDR_W+2:3]`; if `jdo[36]`=1, `monitor_error` <= 0. Stays IDLE.
  - `take_action_ocimem_b`: `MonDReg` <= `jdo[34:3]`; `monitor_ready` <= 0; go to WR_REQ.
  - `take_no_action_ocimem_a`: `monitor_ready` <= 0; go to RD_REQ.
- WR_REQ: `mem_write`=1.
  - Accepted (`mem_waitrequest`=0): address <= address+1; `monitor_ready` <= 1; go to IDLE.
- RD_REQ: `mem_read`=1.
  - Accepted: go to RD_DATA.
- RD_DATA: `MonDReg` <= `mem_readdata`; address <= address+1; `monitor_ready` <= 1; go to IDLE.
- Wait counter (16-bit) clears on entry to WR_REQ/RD_REQ and increments each cycle the request is stalled.
  - When it reaches `TIMEOUT`, the request is dropped: `monitor_error` <= 1, `monitor_ready` <= 1, address unchanged, `MonDReg` unchanged (write data retained); go to IDLE.
- Any command pulse arriving outside IDLE is ignored and sets `monitor_error` <= 1 (overrun). Ignored load-address pulses do not clear the error.
- Address arithmetic is modulo 2^ADDR_W: all-ones + 1 = 0.
- `monitor_error` is sticky; cleared only by reset or a load-address with `jdo[36]`=1.

## Timing
- Reset values: `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0, `mem_read`=0, `mem_write`=0, address=0, FSM=IDLE.
- Reset asserted mid-access aborts immediately; the request drops in the cycle after reset is sampled.
- Command pulse in cycle N: `mem_read`/`mem_write` asserted and `monitor_ready`=0 from N+1.
- Zero-wait write: accepted in N+1; `monitor_ready`=1 and address+1 visible at N+2.
- Zero-wait read: accepted N+1; data sampled at N+2; `MonDReg`, `monitor_ready` and address updated, visible at N+3.
- Stall of k cycles (k < TIMEOUT) adds k cycles to the above latencies.
- Timeout: request held for exactly `TIMEOUT` cycles, then deasserted; flags visible in the next cycle.
- `mem_address`/`mem_writedata` stable for the whole time a request is asserted.
- Load-address takes effect at N+1.

## Test plan
- Reset: assert `reset` 2 cycles with random inputs -> `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0, no requests.
- Load addr 0x10, write 0xDEADBEEF, zero wait -> `mem_write` at N+1 with addr 0x10; ready at N+2; next read hits 0x11. Read back at 0x10 returning 0xDEADBEEF -> `MonDReg`=0xDEADBEEF at N+3.
- Wrap: load 0xFF, two reads -> addresses 0xFF then 0x00.
- Stall: waitrequest high 5 cycles on a read -> ready rises 5 cycles later than zero-wait, no error. With `TIMEOUT`=4 and a permanent stall -> request held 4 cycles, `monitor_error`=1, address unchanged.
- Overrun: read pulse while in RD_REQ -> ignored, `monitor_error`=1. Load with `jdo[36]`=1 in IDLE -> error cleared.
- Simultaneous `take_action_ocimem_a` and `take_action_ocimem_b` -> only the address loads; no write issued.
